// File: rtl/fb_clear_if.sv
// Clear-handshake and frame-buffer write bundle between sys_controler,
// the clear engine and the frame-buffer write port.
interface fb_clear_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
);
    logic              mem_str_clr;
    logic              swap;
    logic              mem_ready;
    logic              mem_clr_finish;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [PIX_W-1:0]  clr_wdata;
    logic              clr_buf;
    logic              clr_done;

    modport master (
        output mem_str_clr, swap, mem_ready,
        input  mem_clr_finish, clr_we, clr_addr, clr_wdata, clr_buf, clr_done
    );

    modport slave (
        input  mem_str_clr, swap, mem_ready,
        output mem_clr_finish, clr_we, clr_addr, clr_wdata, clr_buf, clr_done
    );
endinterface

// File: rtl/fb_clear_engine.sv
// Frame-buffer clear responder: on a rising mem_str_clr it writes CLR_COLOR to
// every pixel of the back buffer, then reports completion on mem_clr_finish.
module fb_clear_engine #(
    parameter int unsigned          FB_DEPTH  = 76800,
    parameter int                   ADDR_W    = 17,
    parameter int                   PIX_W     = 8,
    parameter logic [PIX_W-1:0]     CLR_COLOR = '0
) (
    input  logic        clk,
    input  logic        rst,
    fb_clear_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t state;
    logic   req_q;
    logic   req_edge;
    logic   accept;

    assign req_edge = bus.mem_str_clr & ~req_q;
    assign accept   = bus.clr_we & bus.mem_ready;

    // NOTE: all state and outputs use non-blocking assignments so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            req_q              <= 1'b0;
            bus.mem_clr_finish <= 1'b1;
            bus.clr_we         <= 1'b0;
            bus.clr_addr       <= '0;
            bus.clr_wdata      <= CLR_COLOR;
            bus.clr_buf        <= 1'b0;
            bus.clr_done       <= 1'b0;
        end else begin
            req_q         <= bus.mem_str_clr;
            bus.clr_wdata <= CLR_COLOR;
            bus.clr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        state              <= CLEAR;
                        bus.clr_buf        <= ~bus.swap;
                        bus.clr_addr       <= '0;
                        bus.clr_we         <= 1'b1;
                        bus.mem_clr_finish <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Requests seen here are dropped; a stall simply holds addr/we.
                    if (accept) begin
                        if (bus.clr_addr == LAST_ADDR) begin
                            state              <= IDLE;
                            bus.clr_we         <= 1'b0;
                            bus.clr_addr       <= '0;
                            bus.mem_clr_finish <= 1'b1;
                            bus.clr_done       <= 1'b1;
                        end else begin
                            bus.clr_addr <= bus.clr_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
